// File: rtl/cv32e40x_pkg.sv
// Shared types and constants for the IF-stage fetch address sequencer.
package cv32e40x_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam logic [ADDR_W-1:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [ADDR_W-1:0] FETCH_STEP = 32'd4;

  typedef enum logic {
    FSEQ_IDLE,
    FSEQ_RUN
  } fetch_seq_state_e;

  function automatic logic [ADDR_W-1:0] fetch_align(input logic [ADDR_W-1:0] addr);
    return addr & FETCH_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/cv32e40x_fetch_txn_cnt.sv
// Outstanding-transaction and stale-response (discard) counters for the fetch bus.
module cv32e40x_fetch_txn_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_rvalid,
  input  logic          i_redirect,
  output logic [CW-1:0] o_outstanding,
  output logic          o_resp_valid
);

  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] w_out_next;

  always_comb begin
    w_out_next = r_outstanding;
    if (i_inc && !i_rvalid && (r_outstanding < CW'(MAX_OUTSTANDING))) begin
      w_out_next = r_outstanding + CW'(1);
    end else if (!i_inc && i_rvalid && (r_outstanding != '0)) begin
      w_out_next = r_outstanding - CW'(1);
    end
  end

  // A redirect marks everything granted so far, including this cycle, as stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (i_redirect) begin
        r_discard <= w_out_next;
      end else if (i_rvalid && (r_discard != '0)) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

  assign o_outstanding = r_outstanding;
  assign o_resp_valid  = i_rvalid & (r_discard == '0) & ~i_redirect;

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    i_rvalid |-> (r_outstanding != '0));
  a_max_out: assert property (@(posedge clk) disable iff (rst)
    r_outstanding <= CW'(MAX_OUTSTANDING));
  a_discard_le_out: assert property (@(posedge clk) disable iff (rst)
    r_discard <= r_outstanding);

endmodule

// File: rtl/cv32e40x_fetch_pc_seq.sv
// IF-stage fetch address sequencer: boot, sequential +4 fetch, branch/jump redirect with flush.
module cv32e40x_fetch_pc_seq
  import cv32e40x_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] boot_addr_i,
  input  logic        fetch_enable_i,
  input  logic        halt_i,
  input  logic        bch_taken_i,
  input  logic [31:0] bch_target_i,
  input  logic        jmp_taken_i,
  input  logic [31:0] jmp_target_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_gnt_i,
  input  logic        fetch_rvalid_i,
  output logic        resp_valid_o,
  output logic        kill_o,
  output logic        hw_offset_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  fetch_seq_state_e r_state;
  logic [31:0]      r_fetch_addr;
  logic             r_kill;
  logic             r_hw_offset;

  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_req_gnt;
  logic [CW-1:0]    w_outstanding;

  // Branch from EX is older than the jump from ID, so it wins.
  assign w_target    = bch_taken_i ? bch_target_i : jmp_target_i;
  assign w_redirect  = (r_state == FSEQ_RUN) & (bch_taken_i | jmp_taken_i);
  assign fetch_req_o = (r_state == FSEQ_RUN) & ~halt_i & (w_outstanding < CW'(MAX_OUTSTANDING));
  assign w_req_gnt   = fetch_req_o & fetch_gnt_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FSEQ_IDLE;
      r_fetch_addr <= '0;
      r_kill       <= 1'b0;
      r_hw_offset  <= 1'b0;
    end else begin
      case (r_state)
        FSEQ_IDLE: begin
          r_kill      <= 1'b0;
          r_hw_offset <= 1'b0;
          if (fetch_enable_i) begin
            r_state      <= FSEQ_RUN;
            r_fetch_addr <= fetch_align(boot_addr_i);
          end
        end
        FSEQ_RUN: begin
          r_kill      <= w_redirect;
          r_hw_offset <= w_redirect & w_target[1];
          if (w_redirect) begin
            r_fetch_addr <= fetch_align(w_target);
          end else if (w_req_gnt) begin
            r_fetch_addr <= r_fetch_addr + FETCH_STEP;
          end
        end
        default: begin
          r_state <= FSEQ_IDLE;
        end
      endcase
    end
  end

  cv32e40x_fetch_txn_cnt #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_txn_cnt (
    .clk          (clk),
    .rst          (rst),
    .i_inc        (w_req_gnt),
    .i_rvalid     (fetch_rvalid_i),
    .i_redirect   (w_redirect),
    .o_outstanding(w_outstanding),
    .o_resp_valid (resp_valid_o)
  );

  assign fetch_addr_o = r_fetch_addr;
  assign kill_o       = r_kill;
  assign hw_offset_o  = r_hw_offset;

  a_addr_aligned: assert property (@(posedge clk) r_fetch_addr[1:0] == 2'b00);
  a_kill_after_redirect: assert property (@(posedge clk) disable iff (rst)
    r_kill |-> $past(w_redirect));

endmodule
